// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM wrapper: frame geometry,
// command codes and the SPI slave state encoding.
package spi_ram_pkg;

  localparam int FRAME_W_DEF = 10;
  localparam int DATA_W_DEF  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    CHK_CMD   = 3'b001,
    WRITE     = 3'b010,
    READ_ADD  = 3'b011,
    READ_DATA = 3'b100
  } state_e;

endpackage

// File: rtl/spi_piso_shift.sv
// Parallel-in serial-out shifter for the MISO path: load a byte, present
// its MSB immediately, then one bit per clk; output returns to 0 when done.
module spi_piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              sdo,
  output logic              last
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (load) begin
      r_shift <= din;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == LAST_CNT) begin
        // last bit has had its full cycle on the line; drop back to 0
        r_shift <= '0;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign sdo  = r_shift[DATA_W-1];
  assign last = r_busy && (r_cnt == LAST_CNT);

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front-end: deserialises MOSI frames into rx_data/rx_valid and,
// for read-data frames, serialises the RAM's tx_data back on MISO.
module spi_slave_if
  import spi_ram_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid
);

  localparam int CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [FRAME_W-2:0] r_shift;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_addr_seen;
  logic               r_done;
  logic               r_tx_taken;

  logic w_load;
  logic w_clr;
  logic w_miso;
  logic w_shift_last;

  // only one RAM response per read-data frame; later strobes are ignored
  assign w_load = (r_state == READ_DATA) && r_done && !r_tx_taken && tx_valid && !SS_n;
  assign w_clr  = (r_state != IDLE) && SS_n;

  spi_piso_shift #(
    .DATA_W(DATA_W)
  ) u_piso (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .load (w_load),
    .din  (tx_data),
    .sdo  (w_miso),
    .last (w_shift_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_addr_seen <= 1'b0;
      r_done      <= 1'b0;
      r_tx_taken  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt      <= '0;
          r_done     <= 1'b0;
          r_tx_taken <= 1'b0;
          if (!SS_n) r_state <= CHK_CMD;
        end
        CHK_CMD: begin
          if (SS_n) begin
            r_state <= IDLE;
          end else begin
            r_shift <= {{(FRAME_W-2){1'b0}}, MOSI};
            r_cnt   <= CNT_W'(1);
            if (!MOSI)            r_state <= WRITE;
            else if (r_addr_seen) r_state <= READ_DATA;
            else                  r_state <= READ_ADD;
          end
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!r_done && r_cnt == LAST_CNT) begin
            // the final bit completes the frame even if SS_n rises on this edge
            r_rx_data  <= {r_shift, MOSI};
            r_rx_valid <= 1'b1;
            r_done     <= 1'b1;
            if (r_state == READ_ADD) r_addr_seen <= 1'b1;
            if (SS_n) r_state <= IDLE;
          end else if (SS_n) begin
            r_state <= IDLE;
          end else if (!r_done) begin
            r_shift <= {r_shift[FRAME_W-3:0], MOSI};
            r_cnt   <= r_cnt + 1'b1;
          end else if (w_load) begin
            r_tx_taken <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_shift_last) r_addr_seen <= 1'b0;
    end
  end

  assign MISO     = w_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised scoreboard bench for spi_slave_if: stimulus queues expected
// frames and MISO bytes, a forked monitor checks them every cycle.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n, SS_n, MOSI, tx_valid;
  logic [7:0] tx_data;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;

  always #5 clk = ~clk;

  spi_slave_if #(
    .FRAME_W(10),
    .DATA_W (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .MISO    (MISO),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );

  typedef struct {
    logic [9:0] data;
    int         cyc;
  } rx_exp_t;

  typedef struct {
    logic [7:0] data;
    int         start;
    int         stop;
  } tx_exp_t;

  rx_exp_t rq[$];
  tx_exp_t mq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  bit m_addr_seen = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    logic       exp_bit;
    logic [7:0] b;
    int         i;
    rx_exp_t    e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_bit = 1'b0;
        if (mq.size() > 0 && cyc >= mq[0].start) begin
          i = cyc - mq[0].start;
          b = mq[0].data;
          if (i < 8 && cyc < mq[0].stop) exp_bit = b[7-i];
          if (i >= 7 || cyc + 1 >= mq[0].stop) void'(mq.pop_front());
        end
        n_tests++;
        if (MISO !== exp_bit) begin
          n_fail++;
          $display("FAIL miso cyc=%0d: got %b, expected %b", cyc, MISO, exp_bit);
        end
        if (rx_valid !== 1'b0) begin
          n_tests++;
          if (rx_valid !== 1'b1 || rq.size() == 0) begin
            n_fail++;
            $display("FAIL rx_valid cyc=%0d: got %b with no frame expected", cyc, rx_valid);
          end else begin
            e = rq.pop_front();
            if (rx_data !== e.data || cyc != e.cyc) begin
              n_fail++;
              $display("FAIL rx_frame: got %h at cyc %0d, expected %h at cyc %0d",
                       rx_data, cyc, e.data, e.cyc);
            end else begin
              $display("[TB] rx frame %h at cyc %0d", rx_data, cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    SS_n = 1'b1;
    for (int k = 0; k < n; k++) begin
      MOSI     = 1'($urandom);
      tx_valid = 1'($urandom);
      tx_data  = 8'($urandom);
      tick();
    end
    tx_valid = 1'b0;
  endtask

  // mode: 0 write, 1 read-address, 2 read-data (chosen by bit9 and addr_seen)
  task automatic run_frame(input logic [9:0] f, input int abort_bits, input bit ss_last,
                           input bit early_tx, input bit offer_tx, input int tx_fixed,
                           input int shift_stop, input bit stop_rst);
    int      mode;
    tx_exp_t te;
    mode     = !f[9] ? 0 : (m_addr_seen ? 2 : 1);
    SS_n     = 1'b0;
    MOSI     = 1'($urandom);
    tx_valid = 1'b0;
    if (abort_bits < 0) rq.push_back('{data: f, cyc: cyc + 11});
    tick();
    for (int b = 9; b >= 0; b--) begin
      if (abort_bits >= 0 && (9 - b) == abort_bits) begin
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        tick();
        return;
      end
      MOSI     = f[b];
      tx_valid = early_tx && (b == 5);
      tx_data  = 8'($urandom);
      if (b == 0 && ss_last) SS_n = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    if (mode == 1) m_addr_seen = 1'b1;
    if (ss_last) return;
    if (offer_tx) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        MOSI = 1'($urandom);
        tick();
      end
      tx_valid = 1'b1;
      tx_data  = (tx_fixed >= 0) ? 8'(tx_fixed) : 8'($urandom);
      if (mode == 2) begin
        te.data  = tx_data;
        te.start = cyc + 1;
        te.stop  = 32'h7fff_ffff;
        mq.push_back(te);
      end
      tick();
      for (int i = 0; i < 9; i++) begin
        if (i == shift_stop) begin
          if (mode == 2 && mq.size() > 0) mq[mq.size()-1].stop = cyc + 1;
          tx_valid = 1'b0;
          if (stop_rst) begin
            rst_n = 1'b0;
            SS_n  = 1'b1;
            tick();
            rst_n       = 1'b1;
            m_addr_seen = 1'b0;
            chk("reset_mid_shift_rx_valid", 32'(rx_valid), 0);
            chk("reset_mid_shift_miso", 32'(MISO), 0);
          end else begin
            SS_n = 1'b1;
            tick();
          end
          return;
        end
        MOSI     = 1'($urandom);
        tx_valid = ($urandom_range(0, 3) == 0);
        tx_data  = 8'($urandom);
        tick();
      end
      tx_valid = 1'b0;
      if (mode == 2) m_addr_seen = 1'b0;
    end
    SS_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [9:0] f;
    int ab, ss_stop, r;
    bit ssl, early, offer, rst_sel;
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    fork
      monitor();
    join_none
    repeat (3) tick();
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_rx_valid", 32'(rx_valid), 0);
    chk("reset_miso", 32'(MISO), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    run_frame(10'h0A5, -1, 0, 0, 1, -1, -1, 0);   // write address, tx ignored
    idle(1);
    run_frame(10'h13C, -1, 0, 0, 0, -1, -1, 0);   // write data
    idle(1);
    run_frame(10'h207, -1, 0, 0, 1, -1, -1, 0);   // read address, tx ignored
    idle(1);
    run_frame(10'h3A5, -1, 0, 0, 1, 8'hB6, -1, 0); // read data -> B6 on MISO
    idle(2);
    run_frame(10'h155, 5, 0, 0, 0, -1, -1, 0);    // abort after 5 bits
    idle(1);
    run_frame(10'h0FF, -1, 0, 0, 0, -1, -1, 0);
    idle(1);
    run_frame(10'h2AA, -1, 0, 0, 0, -1, -1, 0);
    idle(1);
    run_frame(10'h355, -1, 0, 0, 1, 8'h5C, 3, 1); // reset during 4th MISO bit
    idle(1);
    run_frame(10'h2F0, -1, 0, 0, 1, 8'hFF, -1, 0); // must be read-address: no MISO
    idle(1);
    run_frame(10'h3C3, -1, 0, 1, 1, 8'hA7, -1, 0); // early tx_valid ignored
    idle(1);
    run_frame(10'h1E1, -1, 1, 0, 0, -1, -1, 0);   // SS_n rises on completing edge
    idle(2);

    for (int t = 0; t < 60; t++) begin
      f       = 10'($urandom);
      f[9]    = ($urandom_range(0, 9) < 7);
      ab      = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : -1;
      ssl     = (ab < 0) && ($urandom_range(0, 9) == 0);
      early   = ($urandom_range(0, 2) == 0);
      offer   = ($urandom_range(0, 9) < 7);
      r       = $urandom_range(0, 19);
      ss_stop = (r < 4) ? int'($urandom_range(0, 7)) : -1;
      rst_sel = (r == 0);
      run_frame(f, ab, ssl, early, offer, -1, ss_stop, rst_sel);
      idle($urandom_range(1, 3));
    end

    idle(12);
    chk("rx_queue_drained", 32'(rq.size()), 0);
    chk("miso_queue_drained", 32'(mq.size()), 0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
